// File: rtl/tile_rev_trace_buffer_pkg.sv
// Shared layout helpers for the reverse-link trace buffer and its filter.
// Link layout, LSB first: forward bits, return packet, rev.ready_and_rev, rev.v.
package tile_rev_trace_buffer_pkg;

    localparam int ctr_width = 32;

    // Forward channel: address, data, valid and ready.
    function automatic int fwd_width(input int addr_w, input int data_w);
        return addr_w + data_w + 2;
    endfunction

    // Return packet, LSB first: x_cord, y_cord, src_x_cord, src_y_cord, data.
    function automatic int rev_pkt_width(input int data_w, input int x_w, input int y_w);
        return data_w + 2 * x_w + 2 * y_w;
    endfunction

    function automatic int link_sif_width(input int addr_w, input int data_w,
                                          input int x_w, input int y_w);
        return fwd_width(addr_w, data_w) + rev_pkt_width(data_w, x_w, y_w) + 2;
    endfunction

    function automatic int rec_width(input int x_w, input int y_w);
        return ctr_width + 2 * x_w + 2 * y_w;
    endfunction

endpackage

// File: rtl/tile_rev_trace_filter.sv
// Combinational qualifier: return packet from a vcache row to a tile inside the array window.
module tile_rev_trace_filter #(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int num_tiles_x_p  = 4,
    parameter int num_tiles_y_p  = 4
) (
    input  logic [x_cord_width_p-1:0] x_cord,
    input  logic [y_cord_width_p-1:0] y_cord,
    input  logic [y_cord_width_p-1:0] src_y_cord,
    output logic                      hit
);

    // Bounds live at 32 bits so 2*num_tiles never wraps in the coordinate width.
    localparam logic [31:0] x_lo    = 32'(num_tiles_x_p);
    localparam logic [31:0] x_hi    = 32'(2 * num_tiles_x_p);
    localparam logic [31:0] y_lo    = 32'(num_tiles_y_p);
    localparam logic [31:0] y_hi    = 32'(2 * num_tiles_y_p);
    localparam logic [31:0] y_north = 32'(num_tiles_y_p - 1);
    localparam logic [31:0] y_south = 32'(2 * num_tiles_y_p);

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [31:0] src_y_ext;

    assign x_ext     = 32'(x_cord);
    assign y_ext     = 32'(y_cord);
    assign src_y_ext = 32'(src_y_cord);

    assign hit = (x_ext >= x_lo) && (x_ext < x_hi)
              && (y_ext >= y_lo) && (y_ext < y_hi)
              && ((src_y_ext == y_north) || (src_y_ext == y_south));

endmodule

// File: rtl/tile_rev_trace_buffer.sv
// Snoops the endpoint reverse link, queues qualified return events with a timestamp,
// and drains them on a valid/yumi port; overflowing events are counted.
module tile_rev_trace_buffer
    import tile_rev_trace_buffer_pkg::*;
#(
    parameter int addr_width_p   = 32,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int num_tiles_x_p  = 4,
    parameter int num_tiles_y_p  = 4,
    parameter int els_p          = 16,
    localparam int link_sif_width_lp =
        link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    input  logic [link_sif_width_lp-1:0] link_sif_o,
    input  logic [31:0]                  global_ctr_i,
    input  logic                         enable_i,
    output logic                         rec_v_o,
    output logic [31:0]                  rec_ctr_o,
    output logic [x_cord_width_p-1:0]    rec_tile_x_o,
    output logic [y_cord_width_p-1:0]    rec_tile_y_o,
    output logic [x_cord_width_p-1:0]    rec_src_x_o,
    output logic [y_cord_width_p-1:0]    rec_src_y_o,
    input  logic                         rec_yumi_i,
    output logic [31:0]                  drop_count_o,
    output logic                         overflow_o
);

    localparam int fwd_w_lp = fwd_width(addr_width_p, data_width_p);
    localparam int pkt_w_lp = rev_pkt_width(data_width_p, x_cord_width_p, y_cord_width_p);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int xw = x_cord_width_p;
    localparam int yw = y_cord_width_p;

    typedef struct packed {
        logic [ctr_width-1:0] ctr;
        logic [xw-1:0]        tile_x;
        logic [yw-1:0]        tile_y;
        logic [xw-1:0]        src_x;
        logic [yw-1:0]        src_y;
    } rec_s;

    logic [pkt_w_lp-1:0] pkt;
    logic                rev_v;
    logic                rev_ready;
    logic                hit;
    logic                fire;
    rec_s                new_rec;
    rec_s                head;

    assign pkt       = link_sif_i[fwd_w_lp +: pkt_w_lp];
    assign rev_v     = link_sif_i[link_sif_width_lp-1];
    assign rev_ready = link_sif_o[link_sif_width_lp-2];

    assign new_rec.ctr    = global_ctr_i;
    assign new_rec.tile_x = pkt[0 +: xw];
    assign new_rec.tile_y = pkt[xw +: yw];
    assign new_rec.src_x  = pkt[xw + yw +: xw];
    assign new_rec.src_y  = pkt[2 * xw + yw +: yw];

    logic unused_link;
    assign unused_link = ^{link_sif_i[fwd_w_lp-1:0], link_sif_i[link_sif_width_lp-2],
                           pkt[pkt_w_lp-1 -: data_width_p],
                           link_sif_o[link_sif_width_lp-1], link_sif_o[link_sif_width_lp-3:0]};

    tile_rev_trace_filter #(
        .x_cord_width_p(x_cord_width_p),
        .y_cord_width_p(y_cord_width_p),
        .num_tiles_x_p (num_tiles_x_p),
        .num_tiles_y_p (num_tiles_y_p)
    ) filter (
        .x_cord    (new_rec.tile_x),
        .y_cord    (new_rec.tile_y),
        .src_y_cord(new_rec.src_y),
        .hit       (hit)
    );

    assign fire = enable_i && rev_v && rev_ready && hit;

    rec_s                mem [els_p];
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [cnt_w_lp-1:0] count;
    logic [31:0]         drop_count_r;
    logic                overflow_r;
    logic                ready;
    logic                pop;
    logic                push;
    logic                drop;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready = (count != cnt_w_lp'(els_p));
    assign pop   = rec_yumi_i && rec_v_o;
    // A pop frees the slot the same cycle, so a full buffer still accepts the event.
    assign push  = fire && (ready || pop);
    assign drop  = fire && !ready && !pop;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            drop_count_r <= '0;
            overflow_r   <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (drop) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 32'hFFFF_FFFF) drop_count_r <= drop_count_r + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= new_rec;
    end

    assign head         = mem[rd_ptr];
    assign rec_v_o      = (count != '0);
    assign rec_ctr_o    = head.ctr;
    assign rec_tile_x_o = head.tile_x;
    assign rec_tile_y_o = head.tile_y;
    assign rec_src_x_o  = head.src_x;
    assign rec_src_y_o  = head.src_y;
    assign drop_count_o = drop_count_r;
    assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_tile_rev_trace_buffer.sv
// Directed bench for tile_rev_trace_buffer with a 4x4 tile window and a 4-deep buffer.
module tb_tile_rev_trace_buffer;

    localparam int lw = 44;

    logic          clk = 1'b0;
    logic          reset;
    logic [lw-1:0] link_i;
    logic [lw-1:0] link_o;
    logic [31:0]   gctr;
    logic          enable;
    logic          rec_v;
    logic [31:0]   rec_ctr;
    logic [3:0]    rec_tile_x;
    logic [3:0]    rec_tile_y;
    logic [3:0]    rec_src_x;
    logic [3:0]    rec_src_y;
    logic          yumi;
    logic [31:0]   drop_count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tile_rev_trace_buffer #(
        .addr_width_p  (8),
        .data_width_p  (8),
        .x_cord_width_p(4),
        .y_cord_width_p(4),
        .num_tiles_x_p (4),
        .num_tiles_y_p (4),
        .els_p         (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .link_sif_i  (link_i),
        .link_sif_o  (link_o),
        .global_ctr_i(gctr),
        .enable_i    (enable),
        .rec_v_o     (rec_v),
        .rec_ctr_o   (rec_ctr),
        .rec_tile_x_o(rec_tile_x),
        .rec_tile_y_o(rec_tile_y),
        .rec_src_x_o (rec_src_x),
        .rec_src_y_o (rec_src_y),
        .rec_yumi_i  (yumi),
        .drop_count_o(drop_count),
        .overflow_o  (overflow)
    );

    always @(posedge clk) begin
        assert (reset || !yumi || rec_v)
        else begin
            $display("FAIL yumi_legal: yumi=1 while rec_v=%0b", rec_v);
            failures++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, checks=%0d", checks);
        $fatal(1);
    end

    task automatic set_pkt(input logic v, input logic rdy, input logic [3:0] x, input logic [3:0] y,
                           input logic [3:0] sx, input logic [3:0] sy, input logic [31:0] ctr);
        link_i = {v, 1'($urandom_range(0, 1)), 8'($urandom), sy, sx, y, x, 18'($urandom)};
        link_o = {1'($urandom_range(0, 1)), rdy, 24'($urandom), 18'($urandom)};
        gctr   = ctr;
    endtask

    task automatic idle();
        set_pkt(1'b0, 1'b1, 4'd5, 4'd6, 4'd2, 4'd3, gctr + 32'd7);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ctr);
        set_pkt(1'b1, 1'b1, 4'(4 + ctr % 4), 4'(4 + (ctr / 4) % 4), 4'(ctr % 16),
                ctr[0] ? 4'd8 : 4'd3, ctr);
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; yumi = 1'b0;
        idle();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (rec_v !== 1'b0) begin $display("FAIL reset_rec_v: got %0b want 0", rec_v); failures++; end
        checks++; if (drop_count !== 32'd0) begin $display("FAIL reset_drop: got %0d want 0", drop_count); failures++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL reset_ovf: got %0b want 0", overflow); failures++; end
    endtask

    task automatic test_basic();
        set_pkt(1'b1, 1'b1, 4'd5, 4'd6, 4'd2, 4'd3, 32'd100);
        tick();
        idle();
        checks++; if (rec_v !== 1'b1) begin $display("FAIL basic_v: got %0b want 1", rec_v); failures++; end
        checks++; if (rec_ctr !== 32'd100) begin $display("FAIL basic_ctr: got %0d want 100", rec_ctr); failures++; end
        checks++; if (rec_tile_x !== 4'd5) begin $display("FAIL basic_tile_x: got %0d want 5", rec_tile_x); failures++; end
        checks++; if (rec_tile_y !== 4'd6) begin $display("FAIL basic_tile_y: got %0d want 6", rec_tile_y); failures++; end
        checks++; if (rec_src_x !== 4'd2) begin $display("FAIL basic_src_x: got %0d want 2", rec_src_x); failures++; end
        checks++; if (rec_src_y !== 4'd3) begin $display("FAIL basic_src_y: got %0d want 3", rec_src_y); failures++; end
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        checks++; if (rec_v !== 1'b0) begin $display("FAIL basic_drained: got %0b want 0", rec_v); failures++; end
    endtask

    task automatic test_filter();
        logic [3:0] xs [7];
        logic [3:0] ys [7];
        logic [3:0] sys [7];
        logic       rdys [7];
        logic       ens [7];
        xs  = '{4'd3, 4'd8, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        ys  = '{4'd6, 4'd6, 4'd8, 4'd3, 4'd6, 4'd6, 4'd6};
        sys = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd8, 4'd3};
        rdys = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ens  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            enable = ens[i];
            set_pkt(1'b1, rdys[i], xs[i], ys[i], 4'd1, sys[i], 32'(150 + i));
            tick();
            idle();
            enable = 1'b1;
            checks++;
            if (rec_v !== 1'b0) begin
                $display("FAIL filter_reject_%0d: rec_v got %0b want 0", i, rec_v); failures++;
            end
        end
        set_pkt(1'b1, 1'b1, 4'd7, 4'd7, 4'd1, 4'd8, 32'd200);
        tick();
        idle();
        checks++; if (rec_v !== 1'b1) begin $display("FAIL filter_south_v: got %0b want 1", rec_v); failures++; end
        checks++; if (rec_ctr !== 32'd200) begin $display("FAIL filter_south_ctr: got %0d want 200", rec_ctr); failures++; end
        checks++; if (rec_src_y !== 4'd8) begin $display("FAIL filter_south_src_y: got %0d want 8", rec_src_y); failures++; end
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) push(32'(10 + i));
        checks++; if (drop_count !== 32'd2) begin $display("FAIL ovf_drop_count: got %0d want 2", drop_count); failures++; end
        checks++; if (overflow !== 1'b1) begin $display("FAIL ovf_flag: got %0b want 1", overflow); failures++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec_v !== 1'b1 || rec_ctr !== 32'(10 + i)) begin
                $display("FAIL ovf_order_%0d: got v=%0b ctr=%0d want v=1 ctr=%0d", i, rec_v, rec_ctr, 10 + i);
                failures++;
            end
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
        end
        checks++; if (rec_v !== 1'b0) begin $display("FAIL ovf_empty: got %0b want 0", rec_v); failures++; end
    endtask

    task automatic test_full_yumi();
        logic [31:0] exp_ctr [4];
        exp_ctr = '{32'd41, 32'd42, 32'd43, 32'd50};
        for (int i = 0; i < 4; i++) push(32'(40 + i));
        set_pkt(1'b1, 1'b1, 4'd6, 4'd5, 4'd3, 4'd3, 32'd50);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        idle();
        checks++; if (drop_count !== 32'd2) begin $display("FAIL full_yumi_drop: got %0d want 2", drop_count); failures++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec_v !== 1'b1 || rec_ctr !== exp_ctr[i]) begin
                $display("FAIL full_yumi_order_%0d: got v=%0b ctr=%0d want v=1 ctr=%0d", i, rec_v, rec_ctr, exp_ctr[i]);
                failures++;
            end
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
        end
        checks++; if (rec_v !== 1'b0) begin $display("FAIL full_yumi_empty: got %0b want 0", rec_v); failures++; end
    endtask

    task automatic test_back_to_back();
        push(32'd70);
        set_pkt(1'b1, 1'b1, 4'd4, 4'd7, 4'd0, 4'd3, 32'd71);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        idle();
        checks++; if (rec_v !== 1'b1) begin $display("FAIL b2b_v: got %0b want 1", rec_v); failures++; end
        checks++; if (rec_ctr !== 32'd71) begin $display("FAIL b2b_ctr: got %0d want 71", rec_ctr); failures++; end
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        checks++; if (rec_v !== 1'b0) begin $display("FAIL b2b_empty: got %0b want 0", rec_v); failures++; end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) push(32'(60 + i));
        force dut.drop_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.drop_count_r;
        push(32'd64);
        checks++; if (drop_count !== 32'hFFFF_FFFF) begin $display("FAIL sat_hold: got %h want ffffffff", drop_count); failures++; end
        push(32'd65);
        checks++; if (drop_count !== 32'hFFFF_FFFF) begin $display("FAIL sat_hold2: got %h want ffffffff", drop_count); failures++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec_ctr !== 32'(60 + i)) begin
                $display("FAIL sat_order_%0d: got ctr=%0d want %0d", i, rec_ctr, 60 + i); failures++;
            end
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(32'(80 + i));
        checks++; if (overflow !== 1'b1) begin $display("FAIL mid_pre_ovf: got %0b want 1", overflow); failures++; end
        reset = 1'b1;
        set_pkt(1'b1, 1'b1, 4'd5, 4'd5, 4'd1, 4'd3, 32'd85);
        tick();
        reset = 1'b0;
        idle();
        checks++; if (rec_v !== 1'b0) begin $display("FAIL mid_rec_v: got %0b want 0", rec_v); failures++; end
        checks++; if (drop_count !== 32'd0) begin $display("FAIL mid_drop: got %0d want 0", drop_count); failures++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL mid_ovf: got %0b want 0", overflow); failures++; end
        push(32'd90);
        checks++; if (rec_v !== 1'b1 || rec_ctr !== 32'd90) begin
            $display("FAIL mid_first: got v=%0b ctr=%0d want v=1 ctr=90", rec_v, rec_ctr); failures++;
        end
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        checks++; if (rec_v !== 1'b0) begin $display("FAIL mid_empty: got %0b want 0", rec_v); failures++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_full_yumi();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
